// File: rtl/hack_alu_pkg.sv
// hack_alu_pkg: control-bit positions and named Hack ALU encodings shared by the ALU datapath.
package hack_alu_pkg;
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] ZERO      = 6'b101010;
    localparam logic [5:0] ONE       = 6'b111111;
    localparam logic [5:0] NEG1      = 6'b111010;
    localparam logic [5:0] X         = 6'b001100;
    localparam logic [5:0] Y         = 6'b110000;
    localparam logic [5:0] NOT_X     = 6'b001101;
    localparam logic [5:0] NEG_X     = 6'b001111;
    localparam logic [5:0] X_PLUS_1  = 6'b011111;
    localparam logic [5:0] X_MINUS_1 = 6'b001110;
    localparam logic [5:0] X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] X_MINUS_Y = 6'b010011;
    localparam logic [5:0] Y_MINUS_X = 6'b000111;
    localparam logic [5:0] X_AND_Y   = 6'b000000;
    localparam logic [5:0] X_OR_Y    = 6'b010101;
endpackage

// File: rtl/alu_preset16.sv
// alu_preset16: optional zeroing then optional inversion of one ALU operand.
module alu_preset16 (
    input  logic [15:0] a,
    input  logic        z,
    input  logic        n,
    output logic [15:0] p
);
    logic [15:0] m;
    assign m = z ? 16'h0000 : a;
    assign p = n ? ~m : m;
endmodule

// File: rtl/and16_gate.sv
// and16_gate: fixed-width 16-bit bitwise AND.
module and16_gate (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);
    assign out = a & b;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage registered Hack ALU with valid/ready handshakes on both sides.
module alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    if (WIDTH != 16) begin : g_bad_width
        $error("alu_pipe: WIDTH must be 16");
    end

    logic        v1_q, v1_d, v2_q, v2_d;
    logic        f_q, f_d, no_q, no_d, zr_q, zr_d, ng_q, ng_d;
    logic [15:0] xp_q, xp_d, yp_q, yp_d, out_q, out_d;
    logic [15:0] xp, yp, and_r, r, res;
    logic        accept, adv2;

    alu_preset16 u_px (.a(x), .z(ctrl[CTRL_ZX]), .n(ctrl[CTRL_NX]), .p(xp));
    alu_preset16 u_py (.a(y), .z(ctrl[CTRL_ZY]), .n(ctrl[CTRL_NY]), .p(yp));
    and16_gate   u_and (.a(xp_q), .b(yp_q), .out(and_r));

    always_comb begin
        adv2     = v1_q && (!v2_q || out_ready);
        in_ready = !v1_q || adv2;
        accept   = in_valid && in_ready;
        v1_d     = accept ? 1'b1 : (adv2 ? 1'b0 : v1_q);
        v2_d     = adv2 ? 1'b1 : (out_ready ? 1'b0 : v2_q);
        xp_d     = accept ? xp : xp_q;
        yp_d     = accept ? yp : yp_q;
        f_d      = accept ? ctrl[CTRL_F] : f_q;
        no_d     = accept ? ctrl[CTRL_NO] : no_q;
        r        = f_q ? xp_q + yp_q : and_r;
        res      = no_q ? ~r : r;
        out_d    = adv2 ? res : out_q;
        zr_d     = adv2 ? (res == 16'h0000) : zr_q;
        ng_d     = adv2 ? res[15] : ng_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            xp_q  <= '0;
            yp_q  <= '0;
            f_q   <= 1'b0;
            no_q  <= 1'b0;
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            xp_q  <= xp_d;
            yp_q  <= yp_d;
            f_q   <= f_d;
            no_q  <= no_d;
            out_q <= out_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
        end
    end

    assign out_valid = v2_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a queue-based reference model.
module tb_alu_pipe;
    import hack_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [5:0]  ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        zr;
    logic        ng;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic        last_acc, popped, stall_prev;
    logic [15:0] pop_val;
    logic [17:0] held;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        logic [15:0] xa, yb, rr;
        xa = c[5] ? 16'h0000 : a;
        if (c[4]) xa = ~xa;
        yb = c[3] ? 16'h0000 : b;
        if (c[2]) yb = ~yb;
        rr = c[1] ? 16'((32'(xa) + 32'(yb)) % 32'h10000) : (xa & yb);
        return c[0] ? ~rr : rr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        popped = 1'b0;
        if (!reset) begin
            if (out_valid) chk("valid_has_pending", 32'(exp_q.size() != 0), 1);
            if (stall_prev && out_valid) chk("stall_stable", {out, zr, ng}, held);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                pop_val = exp_q.pop_front();
                popped = 1'b1;
                chk("sb_out", out, pop_val);
                chk("sb_zr", zr, pop_val == 16'h0000);
                chk("sb_ng", ng, pop_val[15]);
            end
            stall_prev = out_valid && !out_ready;
            held = {out, zr, ng};
            last_acc = in_valid && in_ready;
            if (last_acc) exp_q.push_back(ref_alu(x, y, ctrl));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        ctrl = c;
        x = a;
        y = b;
    endtask

    logic [5:0]  d_c[7]  = '{X_PLUS_Y, X_MINUS_Y, X_AND_Y, X_OR_Y, X_PLUS_Y, ZERO, NEG1};
    logic [15:0] d_x[7]  = '{16'h0005, 16'h0003, 16'h00F0, 16'h00F0, 16'hFFFF, 16'h1234, 16'h5678};
    logic [15:0] d_y[7]  = '{16'h0003, 16'h0005, 16'h0FF0, 16'h0FF0, 16'h0001, 16'h4321, 16'h8765};
    logic [15:0] d_e[7]  = '{16'h0008, 16'hFFFE, 16'h00F0, 16'h0FF0, 16'h0000, 16'h0000, 16'hFFFF};
    logic [5:0]  named[14] = '{ZERO, ONE, NEG1, X, Y, NOT_X, NEG_X, X_PLUS_1, X_MINUS_1,
                               X_PLUS_Y, X_MINUS_Y, Y_MINUS_X, X_AND_Y, X_OR_Y};

    initial begin
        stall_prev = 1'b0;
        held = '0;
        pop_val = '0;
        last_acc = 1'b0;
        popped = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 16'h0000);
        chk("rst_zr", zr, 0);
        chk("rst_ng", ng, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        step();

        // directed operations, one at a time, checking latency and one-cycle pulse
        for (int i = 0; i < 7; i++) begin
            drive(d_c[i], d_x[i], d_y[i]);
            step();
            in_valid = 1'b0;
            chk("lat_n1_valid", out_valid, 0);
            step();
            chk("lat_n2_valid", out_valid, 1);
            chk("dir_out", out, d_e[i]);
            chk("dir_zr", zr, d_e[i] == 16'h0000);
            chk("dir_ng", ng, d_e[i][15]);
            step();
            chk("pulse_end", out_valid, 0);
        end

        // stall: A and B fill the pipe, C is held off
        out_ready = 1'b0;
        drive(X_PLUS_Y, 16'd10, 16'd1);
        step();
        chk("stall_acc_a", last_acc, 1);
        drive(X_PLUS_Y, 16'd20, 16'd2);
        step();
        chk("stall_acc_b", last_acc, 1);
        drive(X_PLUS_Y, 16'd30, 16'd3);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_a", out, 16'd11);
            step();
            chk("stall_no_acc_c", last_acc, 0);
        end
        out_ready = 1'b1;
        step();
        chk("drain_acc_c", last_acc, 1);
        chk("drain_a", {popped, pop_val}, {1'b1, 16'd11});
        in_valid = 1'b0;
        step();
        chk("drain_b", {popped, pop_val}, {1'b1, 16'd22});
        step();
        chk("drain_c", {popped, pop_val}, {1'b1, 16'd33});
        step();
        chk("drain_no_dup", out_valid, 0);

        // full throughput
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(X_PLUS_1, 16'(i), 16'hA5A5);
            else in_valid = 1'b0;
            if (i < 8) chk("tp_in_ready", in_ready, 1);
            step();
            if (i >= 2) chk("tp_val", {popped, pop_val}, {1'b1, 16'(i - 1)});
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            x = 16'($urandom);
            y = 16'($urandom);
            ctrl = ($urandom_range(0, 1) != 0) ? named[$urandom_range(0, 13)] : 6'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk("rand_drained", 32'(exp_q.size()), 0);
        step();
        chk("rand_idle", out_valid, 0);

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(NEG1, 16'h0, 16'h0);
        step();
        drive(ONE, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        chk("full_before_rst", {out_valid, in_ready}, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", out, 16'h0000);
        chk("arst_flags", {zr, ng}, 2'b00);
        exp_q.delete();
        stall_prev = 1'b0;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_in_ready", in_ready, 1);
            chk("post_rst_no_out", out_valid, 0);
            step();
        end
        drive(X_PLUS_Y, 16'd7, 16'd9);
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_new", {out_valid, out}, {1'b1, 16'd16});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
